iterative_alu: RTL and testbench
================================

Name: iterative_alu

Overview:
- Parametrised, handshaked successor to the datapath ALU. Single-cycle ops are add/sub with carry, shifts, logic and compares. Multiply and divide are multi-cycle and iterative.
- Sits between the frequency-counter control FSM and the result registers. Converts gate counts to frequency (divide) and applies scaling (multiply).
- One operation in flight at a time. Results and flags are registered and held until the next completion.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >=4 and a power of two.
- SHAMT_W, $clog2(WIDTH), shift-amount width; derived, not overridable.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  request valid; accepted on an edge where start_i && ready_o.
- flush_i  in  1  synchronous abort of an in-flight mul/div.
- op_i  in  4  opcode (see package).
- signed_i  in  1  1 = two's-complement interpretation for compare/mul/div/SRA.
- carry_i  in  1  carry/borrow in for ADD/SUB.
- operand_a_i  in  WIDTH  operand A / dividend.
- operand_b_i  in  WIDTH  operand B / divisor / shift amount.
- ready_o  out  1  able to accept.
- valid_o  out  1  one-cycle completion pulse.
- result_o  out  WIDTH  result / product low half / quotient.
- result_hi_o  out  WIDTH  product high half / remainder; 0 for other ops.
- carry_o  out  1  ADD carry out / SUB borrow out; 0 for other ops.
- overflow_o  out  1  signed overflow (ADD/SUB, MIN/-1 divide).
- zero_o  out  1  result_o == 0.
- div_zero_o  out  1  divide attempted with divisor 0.
- illegal_o  out  1  reserved opcode accepted.

Behaviour:
- Reset (rst_i low, async):
  - State goes to IDLE.
  - ready_o=1; all other outputs 0.
  - Iteration counter and internal registers 0.
  - Reset mid-iteration discards the operation with no valid_o.
- FSM states IDLE, ITER, FIN.
- IDLE, single-cycle op accepted at edge N:
  - Result and flags are registered at N.
  - valid_o is high for the cycle after N.
  - State stays IDLE with ready_o=1, so back-to-back issue is allowed every cycle.
- IDLE, MUL/DIV accepted at edge N:
  - At N: latch |A|, |B| (if signed_i) and the result sign; counter=0; go to ITER; ready_o=0.
  - ITER: one shift-add (MUL) or restoring-subtract (DIV) step per edge, for WIDTH edges.
  - Then FIN: apply sign correction, register outputs, assert valid_o for one cycle, return to IDLE.
  - valid_o is high in the cycle after edge N+WIDTH+1.
- start_i while ready_o=0 is ignored; operands are not captured.
- flush_i in ITER/FIN returns to IDLE next edge, with no valid_o and outputs unchanged. flush_i in IDLE has no effect. flush_i has priority over FIN completion.
- ADD:
  - {carry_o,result_o} = A + B + carry_i, computed in WIDTH+1 bits.
  - overflow_o = operand MSBs equal and result MSB different.
- SUB:
  - result_o = A - B - carry_i; carry_o = borrow (1 when unsigned A < B + carry_i).
  - overflow_o per two's-complement rule.
- SHL, SHR (logical), SRA (arithmetic) shift by operand_b_i[SHAMT_W-1:0]; upper bits of B are ignored.
- AND, OR, XOR, NOT (NOT acts on A only).
- GT, LT, EQ, NE:
  - result_o = {WIDTH-1 zeros, flag}.
  - GT/LT are signed when signed_i=1.
- MUL: full 2*WIDTH product as {result_hi_o, result_o}; signed if signed_i.
- DIV:
  - Quotient goes to result_o, remainder to result_hi_o.
  - Remainder takes the sign of the dividend (truncating division).
- DIV by zero:
  - No iteration; completes as a single-cycle op.
  - result_o = all ones, result_hi_o = A, div_zero_o=1.
- Signed DIV of MIN by -1: result_o = MIN, result_hi_o=0, overflow_o=1; full WIDTH+2 latency.
- Reserved opcode: result 0, illegal_o=1, single cycle.
- Flags not defined for an op are driven 0 on its completion.

Decomposition:
- Package alu_pkg holds:
  - enum alu_op_e: ADD=0, SUB=1, SHR=2, SHL=3, AND=4, OR=5, NOT=6, XOR=7, GT=8, LT=9, EQ=10, NE=11, MUL=12, DIV=13, SRA=14, RSVD=15.
  - enum alu_state_e.
  - Function is_multicycle(op).
- One sub-module, muldiv_iter. It owns the counter, shift registers and sign fix-up, and exposes start/flush/done. The top level keeps the single-cycle datapath, opcode decode and output registers.

Test Plan:
- WIDTH=32:
  - ADD 0xFFFF_FFFF + 0x1, carry_i=0 -> result 0, carry_o=1, zero_o=1, overflow_o=0, valid_o one cycle after accept.
  - SUB 0x8000_0000 - 0x1 -> result 0x7FFF_FFFF, overflow_o=1, carry_o=0.
  - Back-to-back issue on consecutive cycles: SHL 0x1 by B=0x21, then SRA 0x8000_0000 by 4 (signed_i=1) -> 0x2 (only the low 5 bits of B are used), then 0xF800_0000; ready_o stays 1.
- MUL:
  - Signed MUL -3 x 7 -> {hi,lo} = 0xFFFF_FFFF_FFFF_FFEB, valid_o exactly 34 cycles after accept, ready_o low for 33 cycles.
  - start_i pulsed mid-iteration -> ignored.
- DIV:
  - Signed DIV -7 / 2 -> q=0xFFFF_FFFD, r=0xFFFF_FFFF.
  - DIV 5/0 -> q=0xFFFF_FFFF, r=5, div_zero_o=1, latency 1.
  - Signed DIV 0x8000_0000 / -1 -> q=0x8000_0000, overflow_o=1.
- Interruptions:
  - flush_i in ITER cycle 10 -> no valid_o, ready_o=1 next cycle, previous outputs unchanged.
  - rst_i low mid-MUL -> all outputs 0 immediately; next accepted ADD completes correctly.

Source files
------------

// File: rtl/iterative_alu_pkg.sv
// Shared opcode and state encodings for the iterative ALU and its mul/div engine.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SHR  = 4'd2,
        OP_SHL  = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_NOT  = 4'd6,
        OP_XOR  = 4'd7,
        OP_GT   = 4'd8,
        OP_LT   = 4'd9,
        OP_EQ   = 4'd10,
        OP_NE   = 4'd11,
        OP_MUL  = 4'd12,
        OP_DIV  = 4'd13,
        OP_SRA  = 4'd14,
        OP_RSVD = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIN  = 2'd2
    } alu_state_e;

    function automatic logic is_multicycle(alu_op_e op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/iterative_alu_muldiv_iter.sv
// Iterative magnitude multiplier / restoring divider with sign fix-up.
// Runs WIDTH shift steps in ITER, then presents signed results during FIN.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic             is_div_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output alu_state_e       state_o,
    output logic             done_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o,
    output logic             ovf_o
);

    alu_state_e         state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [WIDTH-1:0]   bmag_q, bmag_d;
    logic               is_div_q, is_div_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic               ovf_q, ovf_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ok;
    logic [2*WIDTH-1:0] prod_raw, prod_fix;

    assign a_neg = signed_i & a_i[WIDTH-1];
    assign b_neg = signed_i & b_i[WIDTH-1];
    assign a_mag = a_neg ? (~a_i + 1'b1) : a_i;
    assign b_mag = b_neg ? (~b_i + 1'b1) : b_i;

    // acc_q holds the product high half (MUL) or partial remainder (DIV);
    // sh_q holds the multiplier shifting out / quotient shifting in.
    assign mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, bmag_q} : {(WIDTH+1){1'b0}});
    assign div_shift = {acc_q, sh_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, bmag_q};
    assign div_ok    = ~div_diff[WIDTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        sh_d     = sh_q;
        bmag_d   = bmag_q;
        is_div_d = is_div_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        ovf_d    = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_ITER;
                    cnt_d    = '0;
                    acc_d    = '0;
                    sh_d     = a_mag;
                    bmag_d   = b_mag;
                    is_div_d = is_div_i;
                    qneg_d   = a_neg ^ b_neg;
                    rneg_d   = a_neg;
                    ovf_d    = is_div_i & signed_i
                             & (a_i == {1'b1, {(WIDTH-1){1'b0}}})
                             & (b_i == {WIDTH{1'b1}});
                end
            end
            ST_ITER: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    if (is_div_q) begin
                        acc_d = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        sh_d  = {sh_q[WIDTH-2:0], div_ok};
                    end else begin
                        acc_d = mul_sum[WIDTH:1];
                        sh_d  = {mul_sum[0], sh_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == SHAMT_W'(WIDTH - 1)) begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            sh_q     <= '0;
            bmag_q   <= '0;
            is_div_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            sh_q     <= sh_d;
            bmag_q   <= bmag_d;
            is_div_q <= is_div_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            ovf_q    <= ovf_d;
        end
    end

    // Remainder follows the dividend sign, giving truncating division.
    assign prod_raw = {acc_q, sh_q};
    assign prod_fix = qneg_q ? (~prod_raw + 1'b1) : prod_raw;

    always_comb begin
        lo_o = prod_fix[WIDTH-1:0];
        hi_o = prod_fix[2*WIDTH-1:WIDTH];
        if (is_div_q) begin
            lo_o = qneg_q ? (~sh_q + 1'b1) : sh_q;
            hi_o = rneg_q ? (~acc_q + 1'b1) : acc_q;
        end
    end

    assign ovf_o   = ovf_q & is_div_q;
    assign done_o  = (state_q == ST_FIN) && !flush_i;
    assign state_o = state_q;

endmodule

// File: rtl/iterative_alu.sv
// Handshaked ALU: single-cycle datapath in this file, MUL/DIV delegated to muldiv_iter.
// Handshake: a request is taken on a rising edge with start_i && ready_o; valid_o pulses one cycle per completion.
module iterative_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [3:0]       op_i,
    input  logic             signed_i,
    input  logic             carry_i,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] result_hi_o,
    output logic             carry_o,
    output logic             overflow_o,
    output logic             zero_o,
    output logic             div_zero_o,
    output logic             illegal_o
);

    alu_op_e            op;
    alu_state_e         md_state;
    logic               accept, div_by_zero, md_start, sc_fire, md_done, md_ovf;
    logic [WIDTH-1:0]   md_lo, md_hi;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH:0]     add_u, add_s, sub_u, sub_s;
    logic signed [WIDTH-1:0] sra_val;
    logic               gt_flag, lt_flag;

    logic [WIDTH-1:0]   sc_lo, sc_hi;
    logic               sc_carry, sc_ovf, sc_dz, sc_ill;

    logic [WIDTH-1:0]   result_q, result_hi_q;
    logic               valid_q, carry_q, overflow_q, zero_q, div_zero_q, illegal_q;

    assign op          = alu_op_e'(op_i);
    assign ready_o     = (md_state == ST_IDLE);
    assign accept      = start_i && ready_o;
    assign div_by_zero = (op == OP_DIV) && (operand_b_i == '0);
    assign md_start    = accept && is_multicycle(op) && !div_by_zero;
    assign sc_fire     = accept && !md_start;

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (md_start),
        .flush_i  (flush_i),
        .is_div_i (op == OP_DIV),
        .signed_i (signed_i),
        .a_i      (operand_a_i),
        .b_i      (operand_b_i),
        .state_o  (md_state),
        .done_o   (md_done),
        .lo_o     (md_lo),
        .hi_o     (md_hi),
        .ovf_o    (md_ovf)
    );

    // Unsigned forms give carry/borrow; sign-extended forms give exact signed overflow.
    assign add_u = {1'b0, operand_a_i} + {1'b0, operand_b_i} + {{WIDTH{1'b0}}, carry_i};
    assign add_s = {operand_a_i[WIDTH-1], operand_a_i} + {operand_b_i[WIDTH-1], operand_b_i}
                 + {{WIDTH{1'b0}}, carry_i};
    assign sub_u = {1'b0, operand_a_i} - {1'b0, operand_b_i} - {{WIDTH{1'b0}}, carry_i};
    assign sub_s = {operand_a_i[WIDTH-1], operand_a_i} - {operand_b_i[WIDTH-1], operand_b_i}
                 - {{WIDTH{1'b0}}, carry_i};

    assign shamt   = operand_b_i[SHAMT_W-1:0];
    assign sra_val = $signed(operand_a_i) >>> shamt;
    assign gt_flag = signed_i ? ($signed(operand_a_i) > $signed(operand_b_i))
                              : (operand_a_i > operand_b_i);
    assign lt_flag = signed_i ? ($signed(operand_a_i) < $signed(operand_b_i))
                              : (operand_a_i < operand_b_i);

    always_comb begin
        sc_lo    = '0;
        sc_hi    = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        sc_dz    = 1'b0;
        sc_ill   = 1'b0;
        case (op)
            OP_ADD: begin
                sc_lo    = add_u[WIDTH-1:0];
                sc_carry = add_u[WIDTH];
                sc_ovf   = add_s[WIDTH] ^ add_s[WIDTH-1];
            end
            OP_SUB: begin
                sc_lo    = sub_u[WIDTH-1:0];
                sc_carry = sub_u[WIDTH];
                sc_ovf   = sub_s[WIDTH] ^ sub_s[WIDTH-1];
            end
            OP_SHR: sc_lo = operand_a_i >> shamt;
            OP_SHL: sc_lo = operand_a_i << shamt;
            OP_SRA: sc_lo = signed_i ? sra_val : (operand_a_i >> shamt);
            OP_AND: sc_lo = operand_a_i & operand_b_i;
            OP_OR:  sc_lo = operand_a_i | operand_b_i;
            OP_NOT: sc_lo = ~operand_a_i;
            OP_XOR: sc_lo = operand_a_i ^ operand_b_i;
            OP_GT:  sc_lo = {{(WIDTH-1){1'b0}}, gt_flag};
            OP_LT:  sc_lo = {{(WIDTH-1){1'b0}}, lt_flag};
            OP_EQ:  sc_lo = {{(WIDTH-1){1'b0}}, operand_a_i == operand_b_i};
            OP_NE:  sc_lo = {{(WIDTH-1){1'b0}}, operand_a_i != operand_b_i};
            OP_DIV: begin
                sc_lo = '1;
                sc_hi = operand_a_i;
                sc_dz = 1'b1;
            end
            OP_MUL:  sc_lo = '0;
            default: sc_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q     <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            div_zero_q  <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (sc_fire) begin
                valid_q     <= 1'b1;
                result_q    <= sc_lo;
                result_hi_q <= sc_hi;
                carry_q     <= sc_carry;
                overflow_q  <= sc_ovf;
                zero_q      <= (sc_lo == '0);
                div_zero_q  <= sc_dz;
                illegal_q   <= sc_ill;
            end else if (md_done) begin
                valid_q     <= 1'b1;
                result_q    <= md_lo;
                result_hi_q <= md_hi;
                carry_q     <= 1'b0;
                overflow_q  <= md_ovf;
                zero_q      <= (md_lo == '0);
                div_zero_q  <= 1'b0;
                illegal_q   <= 1'b0;
            end
        end
    end

    assign valid_o     = valid_q;
    assign result_o    = result_q;
    assign result_hi_o = result_hi_q;
    assign carry_o     = carry_q;
    assign overflow_o  = overflow_q;
    assign zero_o      = zero_q;
    assign div_zero_o  = div_zero_q;
    assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_iterative_alu.sv
// Directed plus randomized bench for iterative_alu against a plain-arithmetic reference model.
module tb_iterative_alu;
  import alu_pkg::*;

  localparam int W = 32;
  localparam longint MAXI = 64'sd2147483647;
  localparam longint MINI = -64'sd2147483648;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic c, v, z, dz, il;
    int lat;
  } exp_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, flush, sgn, cin;
  logic [3:0] op;
  logic [W-1:0] a, b;
  logic ready, valid, cout, ovf, zero, dz, ill;
  logic [W-1:0] res, res_hi;

  iterative_alu #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .flush_i(flush),
    .op_i(op), .signed_i(sgn), .carry_i(cin),
    .operand_a_i(a), .operand_b_i(b),
    .ready_o(ready), .valid_o(valid), .result_o(res), .result_hi_o(res_hi),
    .carry_o(cout), .overflow_o(ovf), .zero_o(zero),
    .div_zero_o(dz), .illegal_o(ill)
  );

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] ex);
    checks++;
    assert (obs === ex) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, ex);
    end
  endtask

  // reference model: plain 64-bit arithmetic on the architectural rules
  function automatic exp_t model(input logic [3:0] o, input logic s, input logic c,
                                 input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    longint ux, uy, ax, ay, sx, sy, cl, r, q, rm;
    logic [63:0] u;
    logic signed [W-1:0] xs, sra;
    int amt;
    e.lo = '0; e.hi = '0; e.c = 0; e.v = 0; e.z = 0; e.dz = 0; e.il = 0; e.lat = 1;
    ux = longint'(x);
    uy = longint'(y);
    ax = longint'($signed(x));
    ay = longint'($signed(y));
    sx = s ? ax : ux;
    sy = s ? ay : uy;
    cl = longint'(c);
    amt = int'(y % W);
    xs = x;
    sra = xs >>> amt;
    case (o)
      4'd0: begin
        u = ux + uy + cl; e.lo = u[W-1:0]; e.c = u[W];
        r = ax + ay + cl; e.v = (r > MAXI) || (r < MINI);
      end
      4'd1: begin
        u = ux - uy - cl; e.lo = u[W-1:0]; e.c = (ux < uy + cl);
        r = ax - ay - cl; e.v = (r > MAXI) || (r < MINI);
      end
      4'd2: e.lo = x >> amt;
      4'd3: e.lo = x << amt;
      4'd14: e.lo = s ? sra : (x >> amt);
      4'd4: e.lo = x & y;
      4'd5: e.lo = x | y;
      4'd6: e.lo = ~x;
      4'd7: e.lo = x ^ y;
      4'd8: e.lo = W'(sx > sy);
      4'd9: e.lo = W'(sx < sy);
      4'd10: e.lo = W'(x == y);
      4'd11: e.lo = W'(x != y);
      4'd12: begin
        u = sx * sy; e.lo = u[W-1:0]; e.hi = u[2*W-1:W]; e.lat = W + 2;
      end
      4'd13: begin
        if (y == 0) begin
          e.lo = '1; e.hi = x; e.dz = 1;
        end else begin
          q = sx / sy; rm = sx % sy;
          u = q; e.lo = u[W-1:0];
          u = rm; e.hi = u[W-1:0];
          e.v = s && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
          e.lat = W + 2;
        end
      end
      default: e.il = 1;
    endcase
    e.z = (e.lo == 0);
    return e;
  endfunction

  task automatic cmp_outputs(input string tag, input exp_t e);
    chk({tag, ".lo"}, res, e.lo);
    chk({tag, ".hi"}, res_hi, e.hi);
    chk({tag, ".flags"}, {cout, ovf, zero, dz, ill}, {e.c, e.v, e.z, e.dz, e.il});
  endtask

  // driver: issue one op, optionally pulse start while busy, wait (bounded) for completion
  task automatic run_op(input string tag, input logic [3:0] o, input logic s, input logic c,
                        input logic [W-1:0] x, input logic [W-1:0] y, input int poke_at);
    exp_t e;
    int cyc, rdy_low;
    exp_q.push_back(model(o, s, c, x, y));
    @(negedge clk);
    chk({tag, ".ready_in"}, ready, 1);
    op = o; sgn = s; cin = c; a = x; b = y; start = 1;
    @(negedge clk);
    start = 0; a = $urandom; b = $urandom; cin = 1'($urandom);
    cyc = 1; rdy_low = 0;
    while (!valid && cyc < 200) begin
      if (!ready) rdy_low++;
      if (cyc == poke_at) begin
        start = 1; op = 4'd0; a = $urandom; b = $urandom;
      end
      @(negedge clk);
      start = 0;
      cyc++;
    end
    e = exp_q.pop_front();
    chk({tag, ".latency"}, cyc, e.lat);
    if (e.lat > 1) chk({tag, ".ready_low"}, rdy_low, W + 1);
    cmp_outputs(tag, e);
    @(negedge clk);
    chk({tag, ".pulse"}, valid, 0);
    chk({tag, ".held"}, res, e.lo);
  endtask

  initial begin
    exp_t e;
    logic [W-1:0] prev_lo, prev_hi;
    int vcount;
    logic [3:0] ro;
    logic [W-1:0] rx, ry;

    rst_n = 0; start = 0; flush = 0; sgn = 0; cin = 0; op = 0; a = 0; b = 0;
    repeat (2) @(negedge clk);
    chk("rst.ready", ready, 1);
    chk("rst.res", res, 0);
    chk("rst.hi", res_hi, 0);
    chk("rst.flags", {valid, cout, ovf, zero, dz, ill}, 0);
    rst_n = 1;

    run_op("add_wrap", 4'd0, 0, 0, 32'hFFFF_FFFF, 32'h1, 0);
    chk("add_wrap.const", {cout, zero, ovf, res}, {3'b110, 32'h0});
    run_op("sub_ovf", 4'd1, 0, 0, 32'h8000_0000, 32'h1, 0);
    chk("sub_ovf.const", {ovf, cout, res}, {2'b10, 32'h7FFF_FFFF});

    // back-to-back single-cycle ops
    @(negedge clk);
    exp_q.push_back(model(4'd3, 0, 0, 32'h1, 32'h21));
    op = 4'd3; sgn = 0; cin = 0; a = 32'h1; b = 32'h21; start = 1;
    @(negedge clk);
    e = exp_q.pop_front();
    chk("b2b.valid1", valid, 1);
    chk("b2b.ready1", ready, 1);
    chk("b2b.shl", res, 32'h2);
    cmp_outputs("b2b1", e);
    exp_q.push_back(model(4'd14, 1, 0, 32'h8000_0000, 32'h4));
    op = 4'd14; sgn = 1; a = 32'h8000_0000; b = 32'h4;
    @(negedge clk);
    start = 0;
    e = exp_q.pop_front();
    chk("b2b.valid2", valid, 1);
    chk("b2b.ready2", ready, 1);
    chk("b2b.sra", res, 32'hF800_0000);
    cmp_outputs("b2b2", e);

    // multi-cycle, with a start pulse during iteration that must be ignored
    run_op("mul_s", 4'd12, 1, 0, -32'sd3, 32'd7, 5);
    chk("mul_s.const", {res_hi, res}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("div_s", 4'd13, 1, 0, -32'sd7, 32'd2, 0);
    chk("div_s.const", {res_hi, res}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("div_zero", 4'd13, 0, 0, 32'd5, 32'd0, 0);
    run_op("div_min", 4'd13, 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("rsvd", 4'd15, 0, 0, 32'h1234, 32'h5678, 0);

    // flush in iteration cycle 10
    @(negedge clk);
    prev_lo = res; prev_hi = res_hi;
    op = 4'd12; sgn = 0; a = 32'hDEAD_BEEF; b = 32'h1234_5678; start = 1;
    @(negedge clk);
    start = 0;
    repeat (9) @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("flush.ready", ready, 1);
    chk("flush.valid", valid, 0);
    chk("flush.lo", res, prev_lo);
    chk("flush.hi", res_hi, prev_hi);
    vcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid) vcount++;
    end
    chk("flush.no_valid", vcount, 0);

    // async reset in the middle of a multiply
    @(negedge clk);
    op = 4'd12; sgn = 1; a = 32'h7FFF_0001; b = 32'h0001_0003; start = 1;
    @(negedge clk);
    start = 0;
    repeat (12) @(negedge clk);
    rst_n = 0;
    #1;
    chk("midrst.ready", ready, 1);
    chk("midrst.res", {res_hi, res}, 0);
    chk("midrst.flags", {valid, cout, ovf, zero, dz, ill}, 0);
    @(negedge clk);
    rst_n = 1;
    run_op("post_rst_add", 4'd0, 0, 1, 32'h7FFF_FFFF, 32'h0, 0);

    // randomized ops with boundary-biased operands
    for (int i = 0; i < 40; i++) begin
      ro = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: rx = $urandom;
        1: rx = 32'h0;
        2: rx = 32'h8000_0000;
        default: rx = 32'hFFFF_FFFF;
      endcase
      case ($urandom_range(0, 4))
        0: ry = 32'h0;
        1: ry = 32'hFFFF_FFFF;
        2: ry = 32'($urandom_range(1, 40));
        default: ry = $urandom;
      endcase
      run_op("rand", ro, 1'($urandom), 1'($urandom), rx, ry, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
